// File: rtl/hamming_seq_ctrl_if.sv
// Bundles the job-control, word-input and result handshakes of
// hamming_seq_ctrl.
//
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid and ready are both high. The producer keeps valid and data
// stable until that edge. Ready never depends combinationally on valid.
//
// Signals (the master drives, the slave is the sequencer):
//   start      job request, honoured only while the sequencer is idle
//   busy       high from job acceptance until the result is taken
//   in_valid   word pair present on x_word/y_word
//   in_ready   sequencer accepts a word this cycle
//   x_word     operand-x word k (bits [k*W +: W])
//   y_word     operand-y word k
//   o_valid    result available on o
//   o_ready    consumer takes the result
//   o          Hamming distance of the job, CW bits wide
interface hamming_seq_ctrl_if #(
    parameter int N = 1600,
    parameter int W = 64
);
    localparam int CW = $clog2(N + 1);

    logic          start;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  x_word;
    logic [W-1:0]  y_word;
    logic          o_valid;
    logic          o_ready;
    logic [CW-1:0] o;

    modport master (
        output start, in_valid, x_word, y_word, o_ready,
        input  busy, in_ready, o_valid, o
    );

    modport slave (
        input  start, in_valid, x_word, y_word, o_ready,
        output busy, in_ready, o_valid, o
    );
endinterface

// File: rtl/hamming_seq_ctrl.sv
// Word-serial Hamming-distance sequencer. It takes two N-bit operands as
// NW = ceil(N/W) word pairs. For each pair it registers the masked popcount
// of x^y and adds that count to an accumulator one cycle later. It then
// returns the total on a valid/ready result port.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   bus          hamming_seq_ctrl_if slave modport (start/busy, word stream,
//                result stream)
//   dbg_state_o  current FSM state, for observation only
//                (IDLE=0 LOAD=1 FLUSH1=2 FLUSH2=3 HOLD=4)
module hamming_seq_ctrl #(
    parameter int N = 1600,
    parameter int W = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hamming_seq_ctrl_if.slave     bus,
    output logic [2:0]            dbg_state_o
);
    localparam int NW   = (N + W - 1) / W;
    localparam int LW   = N - (NW - 1) * W;
    localparam int CW   = $clog2(N + 1);
    localparam int CNTW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(NW - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        FLUSH1 = 3'd2,
        FLUSH2 = 3'd3,
        HOLD   = 3'd4
    } state_t;

    // Only bits [LW-1:0] of the final word belong to the operands.
    function automatic logic [W-1:0] last_mask();
        logic [W-1:0] m;
        for (int i = 0; i < W; i++) begin
            m[i] = (i < LW);
        end
        return m;
    endfunction

    localparam logic [W-1:0] LAST_MASK = last_mask();

    // A single word's count is at most min(W, N). That fits in CW bits, so
    // the running sum here cannot wrap.
    function automatic logic [CW-1:0] popcnt(input logic [W-1:0] v);
        logic [CW-1:0] s;
        s = '0;
        for (int i = 0; i < W; i++) begin
            s = s + CW'(v[i]);
        end
        return s;
    endfunction

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   pc_q, pc_d;
    logic            pc_vld_q, pc_vld_d;
    logic [CW-1:0]   o_q, o_d;
    logic [W-1:0]    word_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            pc_q     <= '0;
            pc_vld_q <= 1'b0;
            o_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            pc_q     <= pc_d;
            pc_vld_q <= pc_vld_d;
            o_q      <= o_d;
        end
    end

    assign word_mask = (cnt_q == LAST_IDX) ? LAST_MASK : '1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        pc_d     = pc_q;
        pc_vld_d = 1'b0;
        o_d      = o_q;

        // Second pipeline stage: fold in the count registered last cycle.
        if (pc_vld_q) begin
            acc_d = acc_q + pc_q;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    acc_d   = '0;
                    o_d     = '0;
                end
            end
            LOAD: begin
                if (bus.in_valid) begin
                    pc_d     = popcnt((bus.x_word ^ bus.y_word) & word_mask);
                    pc_vld_d = 1'b1;
                    cnt_d    = cnt_q + CNTW'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = FLUSH1;
                    end
                end
            end
            FLUSH1: begin
                // The final word's count is added on this edge.
                state_d = FLUSH2;
            end
            FLUSH2: begin
                o_d     = acc_q;
                state_d = HOLD;
            end
            HOLD: begin
                if (bus.o_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All handshake outputs decode the state register only.
    assign bus.busy     = (state_q != IDLE);
    assign bus.in_ready = (state_q == LOAD);
    assign bus.o_valid  = (state_q == HOLD);
    assign bus.o        = o_q;
    assign dbg_state_o  = state_q;
endmodule
